// File: rtl/mig_ui_pkg.sv
// Shared definitions for the MIG user-interface responder: command encodings,
// FIFO depth and the packed entry formats held by the command and data FIFOs.
package mig_ui_pkg;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   localparam int UI_FIFO_DEPTH = 4;

   // Entry widths; the responder's ADDR_W/DATA_W may not exceed these.
   localparam int UI_ADDR_W = 29;
   localparam int UI_DATA_W = 128;
   localparam int UI_MASK_W = UI_DATA_W / 8;

   typedef struct packed {
      logic [2:0]           cmd;
      logic [UI_ADDR_W-1:0] addr;
   } cmd_entry_t;

   typedef struct packed {
      logic [UI_DATA_W-1:0] data;
      logic [UI_MASK_W-1:0] mask;
   } data_entry_t;

endpackage

// File: rtl/mig_ui_resp_fifo.sv
// Small synchronous FIFO with registered occupancy; full/empty come straight
// from the count register so ready signals never see same-cycle pops.
module mig_ui_resp_fifo
   import mig_ui_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = UI_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mig_ui_responder.sv
// Stand-in for MIG+PHY+DDR3 at the app_* interface: calibration delay, app_rdy
// backpressure, decoupled write data, in-order execution and fixed read latency.
module mig_ui_responder
   import mig_ui_pkg::*;
#(
   parameter int ADDR_W       = UI_ADDR_W,
   parameter int DATA_W       = UI_DATA_W,
   parameter int MEM_AW       = 10,
   parameter int CALIB_CYCLES = 1000,
   parameter int RD_LATENCY   = 8,
   parameter int STALL_PERIOD = 0
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic [ADDR_W-1:0]   app_addr,
   input  logic [2:0]          app_cmd,
   input  logic                app_en,
   output logic                app_rdy,
   input  logic [DATA_W-1:0]   app_wdf_data,
   input  logic [DATA_W/8-1:0] app_wdf_mask,
   input  logic                app_wdf_wren,
   input  logic                app_wdf_end,
   output logic                app_wdf_rdy,
   output logic [DATA_W-1:0]   app_rd_data,
   output logic                app_rd_data_valid,
   output logic                app_rd_data_end,
   output logic                init_calib_complete,
   output logic                proto_error
);

   localparam int MASK_W = DATA_W / 8;
   localparam int CAL_W  = $clog2(CALIB_CYCLES + 1);

   // Reset release is assumed already synchronous to sys_clk upstream.
   logic             calib_done;
   logic [CAL_W-1:0] calib_cnt;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         calib_cnt  <= '0;
         calib_done <= 1'b0;
      end else if (!calib_done) begin
         calib_cnt <= calib_cnt + CAL_W'(1);
         if (calib_cnt == CAL_W'(CALIB_CYCLES - 1)) calib_done <= 1'b1;
      end
   end

   logic stall_cycle;

   generate
      if (STALL_PERIOD > 0) begin : g_stall
         localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
         logic [SW-1:0] stall_cnt;

         always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n)                             stall_cnt <= '0;
            else if (stall_cnt == SW'(STALL_PERIOD - 1)) stall_cnt <= '0;
            else                                        stall_cnt <= stall_cnt + SW'(1);
         end

         assign stall_cycle = calib_done & (stall_cnt == '0);
      end else begin : g_no_stall
         assign stall_cycle = 1'b0;
      end
   endgenerate

   cmd_entry_t  cmd_din;
   cmd_entry_t  cmd_head;
   data_entry_t dat_din;
   data_entry_t dat_head;
   logic        cmd_full, cmd_empty, cmd_push, cmd_pop;
   logic        dat_full, dat_empty, dat_push, dat_pop;

   assign app_rdy     = calib_done & ~cmd_full & ~stall_cycle;
   assign app_wdf_rdy = calib_done & ~dat_full;
   assign cmd_push    = app_en & app_rdy;
   assign dat_push    = app_wdf_wren & app_wdf_rdy;

   assign cmd_din.cmd  = app_cmd;
   assign cmd_din.addr = UI_ADDR_W'(app_addr);
   assign dat_din.data = UI_DATA_W'(app_wdf_data);
   assign dat_din.mask = UI_MASK_W'(app_wdf_mask);

   mig_ui_resp_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH(UI_FIFO_DEPTH)) u_cmd_fifo (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .push  (cmd_push),
      .din   (cmd_din),
      .pop   (cmd_pop),
      .dout  (cmd_head),
      .full  (cmd_full),
      .empty (cmd_empty)
   );

   mig_ui_resp_fifo #(.WIDTH($bits(data_entry_t)), .DEPTH(UI_FIFO_DEPTH)) u_dat_fifo (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .push  (dat_push),
      .din   (dat_din),
      .pop   (dat_pop),
      .dout  (dat_head),
      .full  (dat_full),
      .empty (dat_empty)
   );

   // A write at the head waits for its data and holds back everything behind it.
   logic              exec_wr, exec_rd, exec_ill;
   logic [MEM_AW-1:0] exec_idx;
   logic [DATA_W-1:0] wr_data;
   logic [MASK_W-1:0] wr_mask;

   assign exec_wr  = ~cmd_empty & (cmd_head.cmd == CMD_WRITE) & ~dat_empty;
   assign exec_rd  = ~cmd_empty & (cmd_head.cmd == CMD_READ);
   assign exec_ill = ~cmd_empty & (cmd_head.cmd != CMD_WRITE) & (cmd_head.cmd != CMD_READ);
   assign cmd_pop  = exec_wr | exec_rd | exec_ill;
   assign dat_pop  = exec_wr;
   assign exec_idx = cmd_head.addr[MEM_AW+2:3];
   assign wr_data  = DATA_W'(dat_head.data);
   assign wr_mask  = MASK_W'(dat_head.mask);

   logic unused_addr_bits;
   assign unused_addr_bits = ^{cmd_head.addr[UI_ADDR_W-1:MEM_AW+3], cmd_head.addr[2:0]};

   logic [DATA_W-1:0] ram [2**MEM_AW];

   always_ff @(posedge sys_clk) begin
      if (exec_wr) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (!wr_mask[b]) ram[exec_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end

   // Read pipeline: stage 0 is the RAM read, stage RD_LATENCY-1 drives the port.
   logic [DATA_W-1:0]     rd_data_p [RD_LATENCY];
   logic [RD_LATENCY-1:0] vld_p;

   always_ff @(posedge sys_clk) begin
      if (exec_rd) rd_data_p[0] <= ram[exec_idx];
      for (int i = 1; i < RD_LATENCY; i++) rd_data_p[i] <= rd_data_p[i-1];
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) vld_p <= '0;
      else            vld_p <= {vld_p[RD_LATENCY-2:0], exec_rd};
   end

   assign app_rd_data_valid = vld_p[RD_LATENCY-1];
   assign app_rd_data_end   = vld_p[RD_LATENCY-1];
   assign app_rd_data       = vld_p[RD_LATENCY-1] ? rd_data_p[RD_LATENCY-1] : '0;

   logic bad_cmd, bad_wdf;

   assign bad_cmd = cmd_push & (((app_cmd != CMD_WRITE) & (app_cmd != CMD_READ)) |
                                (app_addr[2:0] != 3'b000));
   assign bad_wdf = dat_push & ~app_wdf_end;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)              proto_error <= 1'b0;
      else if (bad_cmd | bad_wdf) proto_error <= 1'b1;
   end

   assign init_calib_complete = calib_done;

endmodule

// File: tb/tb_mig_ui_responder.sv
// Scoreboard bench for mig_ui_responder: reads push expected data/cycle at
// acceptance, a negedge monitor pops and compares each app_rd_data_valid beat.
`timescale 1ns/1ps
module tb_mig_ui_responder;
   import mig_ui_pkg::*;

   localparam int ADDR_W = 29;
   localparam int DATA_W = 128;
   localparam int MASK_W = DATA_W / 8;
   localparam int RD_LAT = 8;
   localparam int CALIB  = 1000;
   localparam logic [DATA_W-1:0] D_BASIC = 128'h0123456789ABCDEF0123456789ABCDEF;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n = 1'b0;
   logic [ADDR_W-1:0] app_addr = '0;
   logic [2:0]        app_cmd = CMD_READ;
   logic              app_en = 1'b0;
   logic              app_rdy;
   logic [DATA_W-1:0] app_wdf_data = '0;
   logic [MASK_W-1:0] app_wdf_mask = '0;
   logic              app_wdf_wren = 1'b0;
   logic              app_wdf_end = 1'b1;
   logic              app_wdf_rdy;
   logic [DATA_W-1:0] app_rd_data;
   logic              app_rd_data_valid, app_rd_data_end, init_calib_complete, proto_error;

   logic              s_app_rdy, s_app_wdf_rdy, s_rd_valid, s_rd_end, s_calib, s_perr;
   logic [DATA_W-1:0] s_rd_data;
   logic [ADDR_W-1:0] s_addr = '0;
   logic [2:0]        s_cmd = CMD_READ;
   logic              s_en = 1'b0, s_wren = 1'b0, s_wend = 1'b1;
   logic [DATA_W-1:0] s_wdata = '0;
   logic [MASK_W-1:0] s_wmask = '0;

   mig_ui_responder #(.CALIB_CYCLES(CALIB), .RD_LATENCY(RD_LAT), .STALL_PERIOD(0)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .app_addr(app_addr), .app_cmd(app_cmd),
      .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
      .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
      .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
      .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
      .init_calib_complete(init_calib_complete), .proto_error(proto_error));

   mig_ui_responder #(.CALIB_CYCLES(CALIB), .RD_LATENCY(RD_LAT), .STALL_PERIOD(4)) dut_s (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .app_addr(s_addr), .app_cmd(s_cmd),
      .app_en(s_en), .app_rdy(s_app_rdy), .app_wdf_data(s_wdata),
      .app_wdf_mask(s_wmask), .app_wdf_wren(s_wren), .app_wdf_end(s_wend),
      .app_wdf_rdy(s_app_wdf_rdy), .app_rd_data(s_rd_data),
      .app_rd_data_valid(s_rd_valid), .app_rd_data_end(s_rd_end),
      .init_calib_complete(s_calib), .proto_error(s_perr));

   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [DATA_W-1:0] sb_data[$];
   int                sb_cyc[$];

   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(negedge sys_clk) begin
      if (app_rd_data_valid) begin
         if (sb_data.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rd_unexpected: valid beat data=%h at cycle %0d, required no beat", app_rd_data, cyc);
         end else begin
            logic [DATA_W-1:0] ed;
            int ec;
            ed = sb_data.pop_front();
            ec = sb_cyc.pop_front();
            n_checks++;
            if (app_rd_data !== ed) begin
               n_fail++;
               $display("FAIL rd_data: got %h, required %h", app_rd_data, ed);
            end
            n_checks++;
            if (app_rd_data_end !== 1'b1) begin
               n_fail++;
               $display("FAIL rd_end: got %b, required 1", app_rd_data_end);
            end
            if (ec >= 0) begin
               n_checks++;
               if (cyc != ec) begin
                  n_fail++;
                  $display("FAIL rd_latency: beat at cycle %0d, required cycle %0d", cyc, ec);
               end
            end
         end
      end
   end

   // Driver helpers: entered and left at posedge+1.
   task automatic issue_cmd(input logic [2:0] cmd, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] exp, input bit chk_lat, input bit exp_beat);
      bit done = 0;
      app_en = 1'b1; app_cmd = cmd; app_addr = addr;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge sys_clk);
         if (app_rdy) begin
            done = 1;
            if (exp_beat) begin
               sb_data.push_back(exp);
               sb_cyc.push_back(chk_lat ? cyc + RD_LAT + 1 : -1);
            end
         end
         @(posedge sys_clk); #1;
      end
      app_en = 1'b0;
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL cmd_timeout: app_rdy stayed 0, required 1 within 2000 cycles");
      end
   endtask

   task automatic push_data(input logic [DATA_W-1:0] data, input logic [MASK_W-1:0] mask);
      bit done = 0;
      app_wdf_wren = 1'b1; app_wdf_data = data; app_wdf_mask = mask;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge sys_clk);
         if (app_wdf_rdy) done = 1;
         @(posedge sys_clk); #1;
      end
      app_wdf_wren = 1'b0;
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL wdf_timeout: app_wdf_rdy stayed 0, required 1 within 2000 cycles");
      end
   endtask

   task automatic issue_wr(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input logic [MASK_W-1:0] mask);
      bit c_done = 0, d_done = 0, c_acc, d_acc;
      app_en = 1'b1; app_cmd = CMD_WRITE; app_addr = addr;
      app_wdf_wren = 1'b1; app_wdf_data = data; app_wdf_mask = mask;
      for (int i = 0; i < 2000 && !(c_done && d_done); i++) begin
         @(negedge sys_clk);
         c_acc = app_en & app_rdy;
         d_acc = app_wdf_wren & app_wdf_rdy;
         @(posedge sys_clk); #1;
         if (c_acc) begin c_done = 1; app_en = 1'b0; end
         if (d_acc) begin d_done = 1; app_wdf_wren = 1'b0; end
      end
      app_en = 1'b0; app_wdf_wren = 1'b0;
      if (!(c_done && d_done)) begin
         n_checks++; n_fail++;
         $display("FAIL wr_timeout: cmd_acc=%b data_acc=%b, required both 1", c_done, d_done);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && sb_data.size() > 0; i++) @(negedge sys_clk);
      repeat (2) @(posedge sys_clk);
      #1;
      n_checks++;
      if (sb_data.size() != 0) begin
         n_fail++;
         $display("FAIL rd_missing: %0d beats outstanding, required 0", sb_data.size());
      end
   endtask

   task automatic wait_calib(input string tag);
      int n = 0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      while (!init_calib_complete && n < CALIB + 100) begin
         @(posedge sys_clk); #1;
         n++;
         if (!init_calib_complete && (app_rdy || app_wdf_rdy)) begin
            n_checks++; n_fail++;
            $display("FAIL %s_rdy_early: app_rdy=%b wdf_rdy=%b at edge %0d, required 0", tag, app_rdy, app_wdf_rdy, n);
         end
      end
      n_checks++;
      if (n != CALIB) begin
         n_fail++;
         $display("FAIL %s_rise: calib rose after %0d edges, required %0d", tag, n, CALIB);
      end
      n_checks++;
      if (app_rdy !== 1'b1 || app_wdf_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_rdy: app_rdy=%b wdf_rdy=%b after calib, required 1/1", tag, app_rdy, app_wdf_rdy);
      end
   endtask

   task automatic test_reset();
      app_en = 1'b1; app_cmd = CMD_READ; app_addr = '0;
      #12;
      n_checks++;
      if ({app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete,
           proto_error, s_app_rdy} !== 7'b0 || app_rd_data !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: rdy=%b wdf_rdy=%b vld=%b end=%b calib=%b perr=%b s_rdy=%b data=%h, required all 0",
                  app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete,
                  proto_error, s_app_rdy, app_rd_data);
      end
   endtask

   task automatic test_calibration();
      int early = 0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int i = 1; i <= CALIB; i++) begin
         @(posedge sys_clk); #1;
         if (i < CALIB) begin
            if (app_rdy || app_wdf_rdy || init_calib_complete || s_app_rdy) early++;
         end else begin
            app_en = 1'b0;
            n_checks++;
            if (init_calib_complete !== 1'b1 || app_rdy !== 1'b1) begin
               n_fail++;
               $display("FAIL calib_rise: calib=%b rdy=%b at edge %0d, required 1/1", init_calib_complete, app_rdy, i);
            end
         end
      end
      n_checks++;
      if (early != 0) begin
         n_fail++;
         $display("FAIL calib_early: %0d cycles with rdy/calib high before edge %0d, required 0", early, CALIB);
      end
   endtask

   task automatic test_basic();
      issue_wr(29'h40, D_BASIC, '0);
      issue_cmd(CMD_READ, 29'h40, D_BASIC, 1'b1, 1'b1);
      wait_drain();
      n_checks++;
      if (proto_error !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_perr: proto_error=%b, required 0", proto_error);
      end
   endtask

   task automatic test_masked();
      issue_wr(29'h80, {DATA_W{1'b1}}, '0);
      issue_wr(29'h80, '0, 16'h00FF);
      issue_cmd(CMD_READ, 29'h80, 128'h0000000000000000FFFFFFFFFFFFFFFF, 1'b0, 1'b1);
      wait_drain();
   endtask

   task automatic test_decoupling();
      logic [DATA_W-1:0] d [8];
      for (int i = 0; i < 8; i++) d[i] = {4{$urandom()}};
      for (int i = 0; i < 4; i++) push_data(d[i], '0);
      @(negedge sys_clk);
      n_checks++;
      if (app_wdf_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL data_first_full: app_wdf_rdy=%b after 4 beats, required 0", app_wdf_rdy);
      end
      @(posedge sys_clk); #1;
      for (int i = 0; i < 4; i++) issue_cmd(CMD_WRITE, ADDR_W'(8 * i), '0, 1'b0, 1'b0);
      for (int i = 4; i < 8; i++) issue_cmd(CMD_WRITE, ADDR_W'(8 * i), '0, 1'b0, 1'b0);
      @(negedge sys_clk);
      n_checks++;
      if (app_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL cmd_first_full: app_rdy=%b after 4 blocked writes, required 0", app_rdy);
      end
      @(posedge sys_clk); #1;
      for (int i = 4; i < 8; i++) push_data(d[i], '0);
      for (int i = 0; i < 8; i++) issue_cmd(CMD_READ, ADDR_W'(8 * i), d[i], 1'b0, 1'b1);
      wait_drain();
   endtask

   task automatic test_errors();
      issue_cmd(3'b010, 29'h40, '0, 1'b0, 1'b0);
      repeat (3) @(posedge sys_clk);
      #1;
      n_checks++;
      if (proto_error !== 1'b1) begin
         n_fail++;
         $display("FAIL illegal_cmd_perr: proto_error=%b, required 1", proto_error);
      end
      issue_cmd(CMD_READ, 29'h40, D_BASIC, 1'b0, 1'b1);
      wait_drain();
      n_checks++;
      if (proto_error !== 1'b1) begin
         n_fail++;
         $display("FAIL perr_sticky: proto_error=%b, required 1", proto_error);
      end
   endtask

   task automatic test_reset_inflight();
      for (int i = 0; i < 3; i++) issue_cmd(CMD_READ, ADDR_W'(8 * i), '0, 1'b0, 1'b0);
      repeat (3) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b0;
      #1;
      n_checks++;
      if ({app_rd_data_valid, app_rdy, app_wdf_rdy, init_calib_complete, proto_error} !== 5'b0) begin
         n_fail++;
         $display("FAIL midreset_outputs: vld=%b rdy=%b wdf_rdy=%b calib=%b perr=%b, required all 0",
                  app_rd_data_valid, app_rdy, app_wdf_rdy, init_calib_complete, proto_error);
      end
      repeat (2) @(posedge sys_clk);
      wait_calib("recalib");
   endtask

   task automatic test_misaligned();
      n_checks++;
      if (proto_error !== 1'b0) begin
         n_fail++;
         $display("FAIL perr_after_reset: proto_error=%b, required 0", proto_error);
      end
      issue_cmd(CMD_READ, 29'h41, D_BASIC, 1'b0, 1'b1);
      wait_drain();
      n_checks++;
      if (proto_error !== 1'b1) begin
         n_fail++;
         $display("FAIL misaligned_perr: proto_error=%b, required 1", proto_error);
      end
   endtask

   task automatic test_stall();
      bit s_low [16];
      int lows = 0, first = -1, bad = 0, base_low = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge sys_clk);
         s_low[k] = !s_app_rdy;
         if (s_low[k]) begin lows++; if (first < 0) first = k; end
         if (!app_rdy) base_low++;
      end
      for (int k = 0; k < 16; k++) if (first >= 0 && s_low[k] != ((k % 4) == (first % 4))) bad++;
      n_checks++;
      if (lows != 4 || bad != 0) begin
         n_fail++;
         $display("FAIL stall_pattern: %0d low cycles in 16 (%0d off-period), required 4 (0)", lows, bad);
      end
      n_checks++;
      if (base_low != 0) begin
         n_fail++;
         $display("FAIL nostall_rdy: %0d low cycles in 16, required 0", base_low);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_calibration();
      test_basic();
      test_masked();
      test_decoupling();
      test_errors();
      test_reset_inflight();
      test_misaligned();
      test_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
